// File: rtl/noc_traffic_injector_pkg.sv
//==============================================================================
// Module      : noc_pkg
// Description : Shared types and constants for the NoC traffic injector.
//               PE count, field widths, the per-slot state encoding, the
//               queued command record and a saturating counter helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package noc_pkg;

    localparam int PE_COUNT = 4;
    localparam int ID_W     = 2;
    localparam int NIBBLE_W = 4;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } slot_state_t;

    typedef struct packed {
        logic [ID_W-1:0]     src;
        logic [ID_W-1:0]     dest;
        logic [NIBBLE_W-1:0] data;
    } cmd_t;

    // Adds a small increment (0..PE_COUNT) and clamps at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_traffic_injector_slot.sv
//==============================================================================
// Module      : noc_inj_slot
// Description : Per-PE injection slot. Holds one dispatched command, drives
//               its nibble/dest toward the PE and tracks the busy handshake.
//               Optional WAIT_BUSY timeout when NOC_INJ_TIMEOUT_EN is defined.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               load            - capture load_dest/load_data (only when idle)
//               pe_busy         - busy from the PE
//               idle            - slot can take a command
//               done            - one-cycle pulse: command completed
//               timeout         - one-cycle pulse: WAIT_BUSY expired
//               nibble_out      - nibble to the NoC (0 = no request)
//               dest_out        - last dispatched destination ID
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module noc_inj_slot
    import noc_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
`ifdef NOC_INJ_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 64
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ID_W-1:0]     load_dest,
    input  logic [NIBBLE_W-1:0] load_data,
    input  logic                pe_busy,
    output logic                idle,
    output logic                done,
    output logic                timeout,
    output logic [NIBBLE_W-1:0] nibble_out,
    output logic [ID_W-1:0]     dest_out
);

    localparam int                  c_hold_w    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    slot_state_t         r_state;
    slot_state_t         w_state_next;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [NIBBLE_W-1:0] r_nibble;
    logic [ID_W-1:0]     r_dest;
    logic                w_expired;

`ifdef NOC_INJ_TIMEOUT_EN
    localparam int                c_to_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

    logic [c_to_w-1:0] r_to_cnt;

    // Counts cycles spent in WAIT_BUSY; the last one without busy expires.
    always_ff @(posedge clk) begin
        if (rst || r_state != WAIT_BUSY) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_expired = (r_to_cnt == c_to_last);
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        done         = 1'b0;
        timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) w_state_next = DRIVE;
            end
            DRIVE: begin
                // busy is ignored here: the nibble must be held first.
                if (r_hold_cnt == c_hold_last) w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy already high on entry is taken as acceptance.
                if (pe_busy) begin
                    w_state_next = WAIT_IDLE;
                end else if (w_expired) begin
                    w_state_next = IDLE;
                    timeout      = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (!pe_busy) begin
                    w_state_next = IDLE;
                    done         = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_nibble   <= '0;
            r_dest     <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == DRIVE) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (r_state == IDLE && load) begin
                r_nibble <= load_data;
                r_dest   <= load_dest;
            end else if (r_state == WAIT_BUSY && w_state_next != WAIT_BUSY) begin
                // Leaving WAIT_BUSY (accepted or expired) withdraws the request;
                // dest is left untouched on purpose.
                r_nibble <= '0;
            end
        end
    end

    assign idle       = (r_state == IDLE);
    assign nibble_out = r_nibble;
    assign dest_out   = r_dest;

endmodule

`default_nettype wire

// File: rtl/noc_traffic_injector.sv
//==============================================================================
// Module      : noc_traffic_injector
// Description : Host-command injector for the 4-PE NoC. Buffers commands in
//               an in-order FIFO, dispatches one per cycle to per-PE slots
//               (head-of-line blocking), drops zero-payload commands, and
//               counts completions and drops with saturation.
//               Build option: NOC_INJ_TIMEOUT_EN enables the WAIT_BUSY timeout
//               and the sticky err_timeout flags (tied to 0 otherwise).
// Ports       : clk, rst                        - clock, sync active-high reset
//               cmd_valid/cmd_ready             - host command handshake
//               cmd_src, cmd_dest, cmd_data     - command fields
//               ext_data_in[16], dest[8]        - per-PE nibble / dest to NoC
//               pe_busy[4]                      - per-PE busy from NoC
//               sent_count, drop_count          - saturating event counters
//               err_timeout[4]                  - sticky per-PE timeout flags
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module noc_traffic_injector
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ID_W-1:0]              cmd_src,
    input  logic [ID_W-1:0]              cmd_dest,
    input  logic [NIBBLE_W-1:0]          cmd_data,
    output logic [PE_COUNT*NIBBLE_W-1:0] ext_data_in,
    output logic [PE_COUNT*ID_W-1:0]     dest,
    input  logic [PE_COUNT-1:0]          pe_busy,
    output logic [CNT_W-1:0]             sent_count,
    output logic [CNT_W-1:0]             drop_count,
    output logic [PE_COUNT-1:0]          err_timeout
);

    localparam int c_aw = $clog2(FIFO_DEPTH);

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    cmd_t            r_fifo [FIFO_DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    cmd_t            w_head;

    logic                r_drop_pending;
    logic                w_drop;
    logic [PE_COUNT-1:0] w_load;
    logic [PE_COUNT-1:0] w_slot_idle;
    logic [PE_COUNT-1:0] w_done;
    logic [PE_COUNT-1:0] w_timeout;
    logic [2:0]          w_done_cnt;
    logic [CNT_W-1:0]    r_sent_count;
    logic [CNT_W-1:0]    r_drop_count;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    // Readiness depends only on fullness, so a same-cycle pop never frees a slot.
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_fifo[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_aw-1:0]] <= '{src: cmd_src, dest: cmd_dest, data: cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Dispatcher: one strictly in-order decision on the head per cycle.
    always_comb begin
        w_pop  = 1'b0;
        w_drop = 1'b0;
        w_load = '0;
        if (!w_empty) begin
            if (w_head.data == '0) begin
                w_pop  = 1'b1;
                w_drop = 1'b1;
            end else if (w_slot_idle[w_head.src]) begin
                w_pop              = 1'b1;
                w_load[w_head.src] = 1'b1;
            end
        end
    end

    // Unused marker keeps the register name aligned with the drop pulse for debug.
    always_ff @(posedge clk) begin
        if (rst) r_drop_pending <= 1'b0;
        else     r_drop_pending <= w_drop;
    end

    generate
        for (genvar i = 0; i < PE_COUNT; i++) begin : g_slot
            noc_inj_slot #(
                .HOLD_CYCLES (HOLD_CYCLES)
`ifdef NOC_INJ_TIMEOUT_EN
                ,
                .TIMEOUT     (TIMEOUT)
`endif
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .load       (w_load[i]),
                .load_dest  (w_head.dest),
                .load_data  (w_head.data),
                .pe_busy    (pe_busy[i]),
                .idle       (w_slot_idle[i]),
                .done       (w_done[i]),
                .timeout    (w_timeout[i]),
                .nibble_out (ext_data_in[NIBBLE_W*i +: NIBBLE_W]),
                .dest_out   (dest[ID_W*i +: ID_W])
            );
        end
    endgenerate

    always_comb begin
        w_done_cnt = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            w_done_cnt = w_done_cnt + {2'b00, w_done[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (|w_done) r_sent_count <= sat_add(r_sent_count, w_done_cnt);
            if (w_drop)  r_drop_count <= sat_add(r_drop_count, 3'd1);
        end
    end

    assign sent_count = r_sent_count;
    assign drop_count = r_drop_count;

`ifdef NOC_INJ_TIMEOUT_EN
    logic [PE_COUNT-1:0] r_err_timeout;

    always_ff @(posedge clk) begin
        if (rst) r_err_timeout <= '0;
        else     r_err_timeout <= r_err_timeout | w_timeout;
    end

    assign err_timeout = r_err_timeout;

    logic w_unused_drop;
    assign w_unused_drop = r_drop_pending;
`else
    localparam int c_unused_timeout = TIMEOUT;

    logic w_unused_sig;
    assign w_unused_sig = (|w_timeout) | r_drop_pending;

    assign err_timeout = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_traffic_injector.sv
//==============================================================================
// Module      : tb_noc_traffic_injector
// Description : Self-checking bench for noc_traffic_injector. Commands with a
//               non-zero payload are queued as expected dispatches and matched
//               by a monitor when a slot's nibble rises; scenario tasks check
//               timing, counters, backpressure and head-of-line blocking.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_noc_traffic_injector;

    localparam int FIFO_DEPTH = 8;
    localparam int HOLD       = 2;
    localparam int TMO        = 64;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_src   = '0;
    logic [1:0]  cmd_dest  = '0;
    logic [3:0]  cmd_data  = '0;
    logic [15:0] ext_data_in;
    logic [7:0]  dest;
    logic [3:0]  pe_busy   = '0;
    logic [15:0] sent_count;
    logic [15:0] drop_count;
    logic [3:0]  err_timeout;

    int errors   = 0;
    int checks   = 0;
    int exp_sent = 0;
    int exp_drop = 0;

    // Expected dispatches in FIFO order: {pe, dest, data}.
    logic [7:0] sb_q[$];
    logic [3:0] prev_nib [4];

    noc_traffic_injector #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_src     (cmd_src),
        .cmd_dest    (cmd_dest),
        .cmd_data    (cmd_data),
        .ext_data_in (ext_data_in),
        .dest        (dest),
        .pe_busy     (pe_busy),
        .sent_count  (sent_count),
        .drop_count  (drop_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Dispatch monitor: a nibble going 0 -> non-zero is a new dispatch.
    always @(negedge clk) begin
        logic [3:0] cur;
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            cur = ext_data_in[4*i +: 4];
            if (!rst && prev_nib[i] == 4'h0 && cur != 4'h0) begin
                got    = {2'(i), dest[2*i +: 2], cur};
                checks = checks + 1;
                if (sb_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL dispatch_unexpected: got pe/dest/data=%h, required none", got);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        errors = errors + 1;
                        $display("FAIL dispatch_order: got pe/dest/data=%h, required %h", got, exp);
                    end
                end
            end
            prev_nib[i] = cur;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cmd(input logic [1:0] s, input logic [1:0] d, input logic [3:0] x);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dest  = d;
        cmd_data  = x;
        if (x != 4'h0) sb_q.push_back({s, d, x});
        else           exp_drop = exp_drop + 1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] s, input logic [1:0] d, input logic [3:0] x);
        drive_cmd(s, d, x);
        wait_accept();
    endtask

    // Completes the command currently (or next) held by slot pe.
    task automatic drain_one(input int pe);
        int n = 0;
        while (ext_data_in[4*pe +: 4] == 4'h0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_start pe%0d: nibble=%h, required non-zero", pe, ext_data_in[4*pe +: 4]);
        end
        cyc(1);
        pe_busy[pe] = 1'b1;
        n = 0;
        while (ext_data_in[4*pe +: 4] != 4'h0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_ack pe%0d: nibble=%h, required 0", pe, ext_data_in[4*pe +: 4]);
        end
        cyc(1);
        pe_busy[pe] = 1'b0;
        exp_sent = exp_sent + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if ({ext_data_in, dest, sent_count, drop_count, err_timeout, cmd_ready} !== {16'h0, 8'h0, 16'h0, 16'h0, 4'h0, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: ext=%h dest=%h sent=%h drop=%h err=%h ready=%b, required 0/0/0/0/0/1",
                     ext_data_in, dest, sent_count, drop_count, err_timeout, cmd_ready);
        end
    endtask

    task automatic test_single();
        send(2'd2, 2'd1, 4'hA);          // accepted at T, now start of T+1
        @(negedge clk);                   // T+1
        checks = checks + 1;
        if (ext_data_in[11:8] !== 4'h0) begin
            errors = errors + 1;
            $display("FAIL single_t1: nibble=%h, required 0", ext_data_in[11:8]);
        end
        @(negedge clk);                   // T+2
        checks = checks + 1;
        if (ext_data_in[11:8] !== 4'hA || dest[5:4] !== 2'd1) begin
            errors = errors + 1;
            $display("FAIL single_t2: nibble=%h dest=%0d, required a/1", ext_data_in[11:8], dest[5:4]);
        end
        cyc(3);                           // start of T+5
        pe_busy[2] = 1'b1;
        @(negedge clk);                   // T+5
        checks = checks + 1;
        if (ext_data_in[11:8] !== 4'hA) begin
            errors = errors + 1;
            $display("FAIL single_t5: nibble=%h, required a", ext_data_in[11:8]);
        end
        @(negedge clk);                   // T+6
        checks = checks + 1;
        if (ext_data_in[11:8] !== 4'h0 || dest[5:4] !== 2'd1) begin
            errors = errors + 1;
            $display("FAIL single_t6: nibble=%h dest=%0d, required 0/1", ext_data_in[11:8], dest[5:4]);
        end
        cyc(2);                           // start of T+8
        pe_busy[2] = 1'b0;
        @(negedge clk);                   // T+8
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL single_t8: sent=%0d, required %0d", sent_count, exp_sent);
        end
        exp_sent = exp_sent + 1;
        @(negedge clk);                   // T+9
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL single_t9: sent=%0d, required %0d", sent_count, exp_sent);
        end
    endtask

    task automatic test_drop();
        send(2'd1, 2'd2, 4'h0);          // accepted at T
        @(negedge clk);                   // T+1
        checks = checks + 1;
        if (drop_count !== 16'(exp_drop - 1)) begin
            errors = errors + 1;
            $display("FAIL drop_t1: drop=%0d, required %0d", drop_count, exp_drop - 1);
        end
        @(negedge clk);                   // T+2
        checks = checks + 1;
        if (drop_count !== 16'(exp_drop) || sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL drop_t2: drop=%0d sent=%0d, required %0d/%0d", drop_count, sent_count, exp_drop, exp_sent);
        end
        repeat (3) begin
            @(negedge clk);
            checks = checks + 1;
            if (ext_data_in[7:4] !== 4'h0) begin
                errors = errors + 1;
                $display("FAIL drop_nibble: pe1 nibble=%h, required 0", ext_data_in[7:4]);
            end
        end
    endtask

    task automatic test_multi_complete();
        int n = 0;
        send(2'd1, 2'd0, 4'h3);
        send(2'd2, 2'd3, 4'hC);
        pe_busy[1] = 1'b1;                // high before WAIT_BUSY is reached
        pe_busy[2] = 1'b1;
        while ((ext_data_in[7:4] != 4'h0 || ext_data_in[11:8] != 4'h0 || n < 2) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (n == 30) begin
            errors = errors + 1;
            $display("FAIL multi_ack: nibbles=%h/%h, required 0/0", ext_data_in[7:4], ext_data_in[11:8]);
        end
        cyc(1);
        pe_busy[1] = 1'b0;
        pe_busy[2] = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL multi_before: sent=%0d, required %0d", sent_count, exp_sent);
        end
        exp_sent = exp_sent + 2;
        @(negedge clk);
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL multi_after: sent=%0d, required %0d", sent_count, exp_sent);
        end
    endtask

    task automatic test_head_of_line();
        pe_busy[0] = 1'b1;                // PE0 never releases busy
        send(2'd0, 2'd1, 4'h5);
        send(2'd0, 2'd2, 4'h6);
        send(2'd3, 2'd3, 4'h7);
        repeat (20) begin
            @(negedge clk);
            checks = checks + 1;
            if (ext_data_in[15:12] !== 4'h0) begin
                errors = errors + 1;
                $display("FAIL hol_pe3: nibble=%h, required 0", ext_data_in[15:12]);
            end
        end
        checks = checks + 1;
        if (ext_data_in[3:0] !== 4'h0 || sent_count !== 16'(exp_sent) || cmd_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL hol_pe0: nibble=%h sent=%0d ready=%b, required 0/%0d/1",
                     ext_data_in[3:0], sent_count, cmd_ready, exp_sent);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_src   = 2'd2;
        cmd_dest  = 2'd0;
        cmd_data  = 4'h5;
        cyc(3);
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        pe_busy    = '0;
        sb_q.delete();
        exp_sent   = 0;
        exp_drop   = 0;
        @(negedge clk);
        checks = checks + 1;
        if ({ext_data_in, dest, sent_count, drop_count, err_timeout, cmd_ready} !== {16'h0, 8'h0, 16'h0, 16'h0, 4'h0, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL reset_mid: ext=%h dest=%h sent=%h drop=%h err=%h ready=%b, required 0/0/0/0/0/1",
                     ext_data_in, dest, sent_count, drop_count, err_timeout, cmd_ready);
        end
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (ext_data_in !== 16'h0 || drop_count !== 16'h0) begin
            errors = errors + 1;
            $display("FAIL reset_flush: ext=%h drop=%0d, required 0/0", ext_data_in, drop_count);
        end
    endtask

    task automatic test_backpressure();
        int stuck = 0;
        send(2'd0, 2'd1, 4'h1);          // occupies slot 0, busy stays low
        for (int k = 2; k <= FIFO_DEPTH + 1; k++) begin
            send(2'd0, 2'(k), 4'(k));
        end
        drive_cmd(2'd0, 2'd3, 4'hA);      // one more than the FIFO holds
        repeat (5) begin
            if (cmd_ready !== 1'b0) stuck++;
            @(negedge clk);
        end
        checks = checks + 1;
        if (stuck != 0) begin
            errors = errors + 1;
            $display("FAIL backpressure_full: cmd_ready high on %0d cycles, required 0", stuck);
        end
        drain_one(0);                     // completion frees the head, then a pop
        wait_accept();
        for (int k = 0; k < FIFO_DEPTH + 1; k++) drain_one(0);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent) || cmd_ready !== 1'b1 || ext_data_in[3:0] !== 4'h0) begin
            errors = errors + 1;
            $display("FAIL backpressure_drain: sent=%0d ready=%b nibble=%h, required %0d/1/0",
                     sent_count, cmd_ready, ext_data_in[3:0], exp_sent);
        end
    endtask

`ifdef NOC_INJ_TIMEOUT_EN
    task automatic test_timeout();
        send(2'd3, 2'd2, 4'h9);          // accepted at T, busy held low
        repeat (HOLD + TMO + 1) @(negedge clk);
        checks = checks + 1;
        if (err_timeout[3] !== 1'b0 || ext_data_in[15:12] !== 4'h9) begin
            errors = errors + 1;
            $display("FAIL timeout_before: err=%b nibble=%h, required 0/9", err_timeout[3], ext_data_in[15:12]);
        end
        @(negedge clk);
        checks = checks + 1;
        if (err_timeout !== 4'b1000 || ext_data_in[15:12] !== 4'h0 || sent_count !== 16'(exp_sent)) begin
            errors = errors + 1;
            $display("FAIL timeout_fire: err=%b nibble=%h sent=%0d, required 1000/0/%0d",
                     err_timeout, ext_data_in[15:12], sent_count, exp_sent);
        end
        send(2'd3, 2'd1, 4'h4);
        drain_one(3);
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent) || err_timeout !== 4'b1000) begin
            errors = errors + 1;
            $display("FAIL timeout_recover: sent=%0d err=%b, required %0d/1000", sent_count, err_timeout, exp_sent);
        end
    endtask
`else
    task automatic test_no_timeout();
        send(2'd3, 2'd2, 4'h9);          // busy held low well past any timeout
        repeat (HOLD + TMO + 8) @(negedge clk);
        checks = checks + 1;
        if (err_timeout !== 4'b0000 || ext_data_in[15:12] !== 4'h9) begin
            errors = errors + 1;
            $display("FAIL no_timeout_wait: err=%b nibble=%h, required 0000/9", err_timeout, ext_data_in[15:12]);
        end
        drain_one(3);
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (sent_count !== 16'(exp_sent) || err_timeout !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL no_timeout_done: sent=%0d err=%b, required %0d/0000", sent_count, err_timeout, exp_sent);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) prev_nib[i] = 4'h0;
        test_reset();
        test_single();
        test_drop();
        test_multi_complete();
        test_head_of_line();
        test_reset_mid();
        test_backpressure();
`ifdef NOC_INJ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_left: %0d dispatches outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
